// File: rtl/hex_display_scanner.sv
// Time-multiplexed seven-segment scanner: snapshots a packed hex value once per frame
// and lights one digit per slot with dead time, decimal points and leading-zero blanking.
module hex_display_scanner #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLKS_PER_DIGIT = 50000,
  parameter int unsigned BLANK_CYCLES   = 100,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned PCNT_W = $clog2(CLKS_PER_DIGIT);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W  = 4 * NUM_DIGITS;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic              SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic              AN_INV    = (AN_ACTIVE_LOW != 0);

  localparam logic [6:0]            SEG_OFF = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};

  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      value_q;
  logic [NUM_DIGITS-1:0] dp_snap_q;
  logic [NUM_DIGITS-1:0] en_snap_q;
  logic                  lzb_q;
  logic                  primed_q;
  logic                  frame_done_q, frame_done_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tick;
  logic                  frame_start;
  logic                  slot_open;
  logic                  lit;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] lzb_blank;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Dead time at the start of each slot keeps the previous digit from ghosting.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign slot_open = 1'b1;
  end else begin : g_blank
    assign slot_open = (pcnt_q >= PCNT_W'(BLANK_CYCLES));
  end

  // Prescaler and digit index.
  always_comb begin
    tick        = (pcnt_q == PCNT_LAST);
    frame_start = tick && (idx_q == IDX_LAST);
    pcnt_d      = tick ? '0 : pcnt_q + PCNT_W'(1);
    idx_d       = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    frame_done_d = frame_start;
  end

  // A digit is blanked while it and every digit above it are zero with no dp.
  always_comb begin
    logic zero_run;
    zero_run  = lzb_q;
    lzb_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (value_q[4*i +: 4] == 4'h0) && !dp_snap_q[i];
      lzb_blank[i] = zero_run && (i != 0);
    end
  end

  always_comb begin
    nib   = value_q[{idx_q, 2'b00} +: 4];
    lit   = primed_q && slot_open && en_snap_q[idx_q] && !lzb_blank[idx_q];
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = SEG_INV;
    if (lit) begin
      an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
      seg_d = glyph(nib) ^ SEG_OFF;
      dp_d  = dp_snap_q[idx_q] ^ SEG_INV;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q       <= PCNT_LAST;
      idx_q        <= IDX_LAST;
      value_q      <= '0;
      dp_snap_q    <= '0;
      en_snap_q    <= '0;
      lzb_q        <= 1'b0;
      primed_q     <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_INV;
      an_q         <= AN_OFF;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      if (frame_start) begin
        value_q   <= value;
        dp_snap_q <= dp_in;
        en_snap_q <= digit_en;
        lzb_q     <= lzb_en;
        primed_q  <= 1'b1;
      end
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
